instruction_fetch: RTL and testbench

//  IF stage plus IF/ID register. Owns the PC, issues in-order requests to instruction memory,

---
 rtl/instruction_fetch_pkg.sv | 28 ++
 rtl/instruction_fetch_queue.sv | 78 +++++++
 rtl/instruction_fetch.sv | 125 ++++++++++++
 tb/tb_instruction_fetch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the fetch stage: slot layout, FSM encoding,
// the decode bubble encoding and the stale-response counter width.
package instruction_fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   // Back-to-back redirects while draining can stack up more stale responses
   // than the queue holds, so the drop counter is sized independently.
   localparam int DROP_W = 8;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            filled;
   } fetch_slot_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Circular fetch slot buffer: alloc at tail on request accept, fill in order
// from responses, pop at head into IF/ID. Flush frees every slot at once.
module instruction_fetch_queue
   import instruction_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     alloc,
   input  logic [XLEN-1:0]          alloc_pc,
   input  logic                     fill,
   input  logic [XLEN-1:0]          fill_data,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   inflight,
   output fetch_slot_t              head_slot,
   output logic                     full
);

   localparam int PW = $clog2(DEPTH);

   fetch_slot_t   slots [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] fptr;
   logic [PW:0]   used;
   logic [PW:0]   nfilled;

   assign count    = used;
   assign inflight = used - nfilled;
   assign full     = (used == (PW+1)'(DEPTH));

   // A head slot being filled this cycle is presented straight from the
   // response bus so a 1-cycle memory sustains one instruction per cycle.
   always_comb begin
      head_slot = slots[head];
      if (!slots[head].filled) head_slot.instr = fill_data;
      head_slot.filled = (used != '0) && (slots[head].filled || (fill && (fptr == head)));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         fptr    <= '0;
         used    <= '0;
         nfilled <= '0;
      end else if (flush) begin
         head    <= '0;
         tail    <= '0;
         fptr    <= '0;
         used    <= '0;
         nfilled <= '0;
      end else begin
         if (alloc) tail <= tail + 1'b1;
         if (fill)  fptr <= fptr + 1'b1;
         if (pop)   head <= head + 1'b1;
         used    <= used + (PW+1)'(alloc) - (PW+1)'(pop);
         nfilled <= nfilled + (PW+1)'(fill) - (PW+1)'(pop);
      end
   end

   // Slot payload needs no reset: occupancy is tracked by the pointers and
   // alloc clears the filled flag before a slot is ever read as valid.
   always_ff @(posedge clk) begin
      if (alloc) begin
         slots[tail].pc     <= alloc_pc;
         slots[tail].filled <= 1'b0;
      end
      if (fill) begin
         slots[fptr].instr  <= fill_data;
         slots[fptr].filled <= 1'b1;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage with IF/ID register: owns the PC, issues in-order imem requests,
// drops responses orphaned by a redirect and feeds decode one word per cycle.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                  WORD_SIZE   = XLEN,
   parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
   parameter int                  QUEUE_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 ImemReqValid,
   input  logic                 ImemReqReady,
   output logic [WORD_SIZE-1:0] ImemAddr,
   input  logic                 ImemRespValid,
   input  logic [WORD_SIZE-1:0] ImemRespData,
   input  logic                 StallD,
   input  logic                 RedirectValid,
   input  logic [WORD_SIZE-1:0] RedirectPC,
   output logic [WORD_SIZE-1:0] InstrD,
   output logic [WORD_SIZE-1:0] PCD,
   output logic [WORD_SIZE-1:0] PCPlus4D,
   output logic                 ValidD
);

   localparam int PW = $clog2(QUEUE_DEPTH);

   fetch_state_t        state;
   logic [WORD_SIZE-1:0] pc;
   logic [DROP_W-1:0]    drop_cnt;
   logic [DROP_W-1:0]    drop_next;

   logic [PW:0]  q_count;
   logic [PW:0]  q_inflight;
   fetch_slot_t  head_slot;
   logic         q_full;

   logic accept;
   logic resp_drop;
   logic resp_fill;
   logic pop;

   assign ImemReqValid = (state != BOOT) && !RedirectValid && !q_full;
   assign ImemAddr     = pc;
   assign accept       = ImemReqValid && ImemReqReady;

   // Responses owed to requests issued before a redirect arrive first and
   // are discarded; only once the debt is paid do responses fill slots.
   assign resp_drop = ImemRespValid && (drop_cnt != '0);
   assign resp_fill = ImemRespValid && (drop_cnt == '0) && (q_inflight != '0);
   assign pop       = !RedirectValid && !StallD && head_slot.filled;

   always_comb begin
      drop_next = drop_cnt - DROP_W'(resp_drop);
      if (RedirectValid)
         drop_next = drop_next + DROP_W'(q_inflight) - DROP_W'(resp_fill);
   end

   instruction_fetch_queue #(
      .DEPTH(QUEUE_DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (RedirectValid),
      .alloc     (accept),
      .alloc_pc  (pc),
      .fill      (resp_fill),
      .fill_data (ImemRespData),
      .pop       (pop),
      .count     (q_count),
      .inflight  (q_inflight),
      .head_slot (head_slot),
      .full      (q_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= BOOT;
         pc       <= RESET_PC;
         drop_cnt <= '0;
      end else begin
         drop_cnt <= drop_next;
         if (RedirectValid)
            pc <= word_align(RedirectPC);
         else if (accept)
            pc <= pc + WORD_SIZE'(4);
         case (state)
            BOOT:    state <= RUN;
            RUN:     if (RedirectValid && (drop_next != '0)) state <= DRAIN;
            DRAIN:   if (drop_next == '0) state <= RUN;
            default: state <= BOOT;
         endcase
      end
   end

   // IF/ID register: redirect squashes even a stalled decode slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= WORD_SIZE'(4);
         ValidD   <= 1'b0;
      end else if (RedirectValid) begin
         InstrD <= NOP_INSTR;
         ValidD <= 1'b0;
      end else if (!StallD) begin
         if (head_slot.filled) begin
            InstrD   <= head_slot.instr;
            PCD      <= head_slot.pc;
            PCPlus4D <= head_slot.pc + WORD_SIZE'(4);
            ValidD   <= 1'b1;
         end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
         end
      end
   end

   a_resp_owed: assert property (@(posedge clk) disable iff (reset)
      ImemRespValid |-> ((q_inflight != '0) || (drop_cnt != '0)));

   a_count_bound: assert property (@(posedge clk) disable iff (reset)
      q_count <= (PW+1)'(QUEUE_DEPTH));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: in-order memory model with selectable
// latency, hand-computed checkpoints plus a running PC-sequence model.
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ImemReqValid;
   logic        ImemReqReady;
   logic [31:0] ImemAddr;
   logic        ImemRespValid;
   logic [31:0] ImemRespData;
   logic        StallD;
   logic        RedirectValid;
   logic [31:0] RedirectPC;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] mq_addr [$];
   int          mq_due [$];

   always #5 clk = ~clk;

   instruction_fetch #(
      .WORD_SIZE   (32),
      .RESET_PC    (32'h0),
      .QUEUE_DEPTH (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ImemReqValid  (ImemReqValid),
      .ImemReqReady  (ImemReqReady),
      .ImemAddr      (ImemAddr),
      .ImemRespValid (ImemRespValid),
      .ImemRespData  (ImemRespData),
      .StallD        (StallD),
      .RedirectValid (RedirectValid),
      .RedirectPC    (RedirectPC),
      .InstrD        (InstrD),
      .PCD           (PCD),
      .PCPlus4D      (PCPlus4D),
      .ValidD        (ValidD)
   );

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[29:0], 2'b11} ^ 32'h5A00_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_reqvalid"}, {31'b0, ImemReqValid}, 32'h0);
      chk({tag, "_addr"},     ImemAddr,              32'h0);
      chk({tag, "_instr"},    InstrD,                NOP_INSTR);
      chk({tag, "_pcd"},      PCD,                   32'h0);
      chk({tag, "_pcplus4"},  PCPlus4D,              32'h4);
      chk({tag, "_valid"},    {31'b0, ValidD},       32'h0);
   endtask

   // One clock: sample pre-edge, advance to the next falling edge, drive the
   // memory response for the new cycle and check the decode stream.
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      logic        st;
      logic        rd;
      logic [31:0] rp;
      #1;
      acc = ImemReqValid && ImemReqReady;
      a   = ImemAddr;
      st  = StallD;
      rd  = RedirectValid;
      rp  = RedirectPC;
      @(negedge clk);
      cyc++;
      if (acc) begin
         mq_addr.push_back(a);
         mq_due.push_back(cyc - 1 + lat);
      end
      if (mq_due.size() != 0 && mq_due[0] <= cyc) begin
         ImemRespValid = 1'b1;
         ImemRespData  = word_of(mq_addr[0]);
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end else begin
         ImemRespValid = 1'b0;
         ImemRespData  = 32'h0;
      end
      if (rd) begin
         exp_pc = rp & ~32'h3;
      end else if (!st && ValidD) begin
         chk("seq_pc",    PCD,      exp_pc);
         chk("seq_instr", InstrD,   word_of(exp_pc));
         chk("seq_pc4",   PCPlus4D, exp_pc + 32'h4);
         exp_pc = exp_pc + 32'h4;
      end
      if (!ValidD) chk("nop_when_invalid", InstrD, NOP_INSTR);
      #1;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      StallD        = 1'b0;
      RedirectValid = 1'b0;
      RedirectPC    = 32'h0;
      ImemRespValid = 1'b0;
      ImemRespData  = 32'h0;
      ImemReqReady  = 1'b1;
      mq_addr.delete();
      mq_due.delete();
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      reset  = 1'b0;
      cyc    = 0;
      exp_pc = 32'h0;
      #1;
   endtask

   initial begin
      // Reset, boot cycle, then 1-cycle memory streaming
      lat = 1;
      do_reset();
      chk("boot_no_req", {31'b0, ImemReqValid}, 32'h0);
      tick();
      chk("c1_req_valid", {31'b0, ImemReqValid}, 32'h1);
      chk("c1_addr", ImemAddr, 32'h0);
      tick();
      chk("c2_valid", {31'b0, ValidD}, 32'h0);
      chk("c2_addr", ImemAddr, 32'h4);
      tick();
      chk("c3_valid", {31'b0, ValidD}, 32'h1);
      chk("c3_pcd", PCD, 32'h0);
      chk("c3_instr", InstrD, word_of(32'h0));
      tick();
      chk("c4_pcd", PCD, 32'h4);
      tick();
      chk("c5_pcd", PCD, 32'h8);
      tick();

      // Stall decode for cycles 6..8
      StallD = 1'b1;
      chk("c6_pcd", PCD, 32'hC);
      tick();
      chk("stall_c7_pcd", PCD, 32'hC);
      chk("stall_c7_req", {31'b0, ImemReqValid}, 32'h0);
      tick();
      chk("stall_c8_pcd", PCD, 32'hC);
      chk("stall_c8_instr", InstrD, word_of(32'hC));
      tick();
      StallD = 1'b0;
      chk("c9_pcd_held", PCD, 32'hC);
      chk("c9_full_req", {31'b0, ImemReqValid}, 32'h0);
      tick();
      chk("c10_pcd", PCD, 32'h10);
      chk("c10_req", {31'b0, ImemReqValid}, 32'h1);
      chk("c10_addr", ImemAddr, 32'h18);
      tick();
      chk("c11_pcd", PCD, 32'h14);
      tick();
      chk("c12_pcd", PCD, 32'h18);
      repeat (3) tick();

      // Latency 3, redirect with two requests in flight
      lat = 3;
      do_reset();
      tick();
      tick();
      tick();
      RedirectValid = 1'b1;
      RedirectPC    = 32'h100;
      #1;
      chk("redir_blocks_req", {31'b0, ImemReqValid}, 32'h0);
      tick();
      RedirectValid = 1'b0;
      #1;
      chk("redir_c4_valid", {31'b0, ValidD}, 32'h0);
      chk("redir_c4_req", {31'b0, ImemReqValid}, 32'h1);
      chk("redir_c4_addr", ImemAddr, 32'h100);
      tick();
      tick();
      tick();
      chk("redir_c7_valid", {31'b0, ValidD}, 32'h0);
      tick();
      chk("redir_c8_valid", {31'b0, ValidD}, 32'h1);
      chk("redir_c8_pcd", PCD, 32'h100);
      chk("redir_c8_instr", InstrD, word_of(32'h100));
      tick();
      chk("redir_c9_pcd", PCD, 32'h104);

      // Redirect beats stall; unaligned target is forced to word alignment
      StallD        = 1'b1;
      RedirectValid = 1'b1;
      RedirectPC    = 32'h0000_0203;
      tick();
      StallD        = 1'b0;
      RedirectValid = 1'b0;
      chk("redir_stall_valid", {31'b0, ValidD}, 32'h0);
      chk("redir_stall_instr", InstrD, NOP_INSTR);
      #1;
      chk("align_addr", ImemAddr, 32'h200);
      chk("align_req", {31'b0, ImemReqValid}, 32'h1);
      repeat (4) tick();
      chk("align_c14_valid", {31'b0, ValidD}, 32'h1);
      chk("align_c14_pcd", PCD, 32'h200);
      repeat (3) tick();

      // PC wrap at the top of the address space
      lat = 1;
      do_reset();
      tick();
      RedirectValid = 1'b1;
      RedirectPC    = 32'hFFFF_FFFC;
      tick();
      RedirectValid = 1'b0;
      #1;
      chk("wrap_addr_top", ImemAddr, 32'hFFFF_FFFC);
      tick();
      chk("wrap_addr_zero", ImemAddr, 32'h0);
      tick();
      chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
      chk("wrap_pcplus4", PCPlus4D, 32'h0);
      tick();
      chk("wrap_next_pcd", PCD, 32'h0);
      tick();

      // Reset with requests outstanding; late responses never arrive
      lat = 3;
      do_reset();
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk_reset_vals("async_reset");
      do_reset();
      chk("rst2_boot", {31'b0, ImemReqValid}, 32'h0);
      tick();
      chk("rst2_addr", ImemAddr, 32'h0);
      repeat (4) tick();
      chk("rst2_valid", {31'b0, ValidD}, 32'h1);
      chk("rst2_pcd", PCD, 32'h0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
